cpu_if: RTL

Instruction fetch stage. It sits directly upstream of the decode stage (cpu_id). It owns the fetch PC and drives a variable-latency instruction-memory request/ack port. It feeds registered if_pc/if_inst to decode and takes the branch/jump redirects that decode produces. PLP has one architectural branch delay slot, and this stage enforces it.

---
 rtl/cpu_if.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cpu_if.sv
// Instruction fetch stage: owns the fetch PC, drives the imem req/ack port and feeds if_pc/if_inst to decode.
// Latency: an ack at cycle t presents its word on if_inst from t+1, so single-cycle acks sustain one instruction per cycle.
// Backpressure: stall freezes if_pc/if_inst; a word acked under stall is parked in HOLD with imem_req low until stall drops.
module cpu_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        c_b,
    input  logic [31:0] baddr,
    input  logic        c_j,
    input  logic [31:0] jaddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc;
    logic [31:0] hold_inst, hold_pc;
    logic [31:0] rd_target;
    logic        rd_pend, rd_done;

    logic [31:0] target, next_pc;
    logic        redir;
    logic        load_mem, load_hold, load_nop, park;
    logic        issue, new_inst;

    // Target is computed against the instruction decode currently holds.
    always_comb begin
        target = baddr;
        if (c_j) begin
            if (if_inst[31:27] == 5'b00001)
                target = {if_pc[31:28], jaddr[25:0], 2'b00};
            else
                target = jaddr;
        end
    end

    assign redir    = (c_b | c_j) & ~rd_done;
    assign next_pc  = rd_pend ? rd_target : (redir ? target : fetch_pc + 32'd4);
    assign issue    = load_mem | load_hold;
    assign new_inst = issue | load_nop;

    assign imem_req  = (state_q == WAIT);
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_mem  = 1'b0;
        load_hold = 1'b0;
        load_nop  = 1'b0;
        park      = 1'b0;
        case (state_q)
            IDLE: state_d = WAIT;
            WAIT: begin
                if (imem_ack) begin
                    if (stall) begin
                        park    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        load_mem = 1'b1;
                    end
                end else if (!stall) begin
                    load_nop = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    load_hold = 1'b1;
                    state_d   = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            if_pc     <= RESET_PC;
            if_inst   <= NOP_INST;
            hold_inst <= '0;
            hold_pc   <= '0;
            rd_target <= '0;
            rd_pend   <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            if (issue)
                fetch_pc <= next_pc;

            if (load_mem) begin
                if_inst <= imem_rdata;
                if_pc   <= fetch_pc;
            end else if (load_hold) begin
                if_inst <= hold_inst;
                if_pc   <= hold_pc;
            end else if (load_nop) begin
                if_inst <= NOP_INST;
            end

            if (park) begin
                hold_inst <= imem_rdata;
                hold_pc   <= fetch_pc;
            end

            // A pending redirect is consumed by this issue; a fresh one arriving at the
            // same time stays queued for the following fetch.
            if (issue) begin
                rd_pend <= rd_pend & redir;
                if (rd_pend && redir)
                    rd_target <= target;
            end else if (redir) begin
                rd_pend   <= 1'b1;
                rd_target <= target;
            end

            if (new_inst)
                rd_done <= 1'b0;
            else if (redir)
                rd_done <= 1'b1;
        end
    end

endmodule
